// File: rtl/deserializer_fifo_if.sv
// Handshake bundle between a serial bit producer and the deserializer's word queue.
// The master side drives bits and acks; the slave side presents queued words.
interface deserializer_fifo_if #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    logic                  data_in;
    logic                  write_in;
    logic                  ack_in;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  data_ready;
    logic                  status_out;
    logic [FILL_W-1:0]     fill;

    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, fill
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, fill
    );
endinterface

// File: rtl/deserializer_fifo.sv
// Serial-to-parallel converter: assembles WORD_WIDTH-bit words one bit per cycle
// and queues them in a FIFO_DEPTH-entry buffer behind a ready/ack handshake.
module deserializer_fifo #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic               clock,
    input  logic               reset,
    deserializer_fifo_if.slave bus
);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_WIDTH - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(FIFO_DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    logic [CNT_W-1:0]      cnt_r;
    logic [WORD_WIDTH-1:0] shift_r;
    logic [WORD_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [FILL_W-1:0]     fill_r;
    logic [WORD_WIDTH-1:0] data_out_r;
    logic                  data_ready_r;
    logic                  status_r;

    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [WORD_WIDTH-1:0] shift_next_s;
    logic [FILL_W-1:0]     fill_next_s;
    logic [FILL_W-1:0]     fill_after_pop_s;
    logic [PTR_W-1:0]      rd_ptr_next_s;
    logic [PTR_W-1:0]      wr_ptr_next_s;
    logic [WORD_WIDTH-1:0] head_next_s;

    // Next-state decode: accept/push/pop qualification, shift, pointers and next queue head.
    always_comb begin
        accept_s         = bus.write_in & ~status_r;
        pop_s            = bus.ack_in & data_ready_r;
        shift_next_s     = shift_r;
        fill_next_s      = fill_r;
        fill_after_pop_s = fill_r;
        rd_ptr_next_s    = rd_ptr_r;
        wr_ptr_next_s    = wr_ptr_r;
        head_next_s      = {WORD_WIDTH{1'b0}};

        if (MSB_FIRST != 0) begin
            shift_next_s = {shift_r[WORD_WIDTH-2:0], bus.data_in};
        end else begin
            shift_next_s = {bus.data_in, shift_r[WORD_WIDTH-1:1]};
        end

        // status_r is full, so a push can never land on a full queue.
        push_s = accept_s & (cnt_r == LAST_BIT);

        case ({push_s, pop_s})
            2'b10:   fill_next_s = fill_r + FILL_W'(1);
            2'b01:   fill_next_s = fill_r - FILL_W'(1);
            default: fill_next_s = fill_r;
        endcase

        if (pop_s) begin
            rd_ptr_next_s    = ptr_inc(rd_ptr_r);
            fill_after_pop_s = fill_r - FILL_W'(1);
        end else begin
            rd_ptr_next_s    = rd_ptr_r;
            fill_after_pop_s = fill_r;
        end

        if (push_s) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        // A word pushed into an otherwise-empty queue bypasses storage to become the head.
        if (fill_next_s == {FILL_W{1'b0}}) begin
            head_next_s = {WORD_WIDTH{1'b0}};
        end else if (fill_after_pop_s == {FILL_W{1'b0}}) begin
            head_next_s = shift_next_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Bit counter, shift register, queue bookkeeping and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r        <= {CNT_W{1'b0}};
            shift_r      <= {WORD_WIDTH{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            fill_r       <= {FILL_W{1'b0}};
            data_out_r   <= {WORD_WIDTH{1'b0}};
            data_ready_r <= 1'b0;
            status_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                shift_r <= shift_next_s;
                if (push_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            fill_r       <= fill_next_s;
            data_out_r   <= head_next_s;
            data_ready_r <= (fill_next_s != {FILL_W{1'b0}});
            status_r     <= (fill_next_s == FULL_FILL);
        end
    end

    // Word storage; occupancy lives in fill_r, so the array itself needs no reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_next_s;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_ready = data_ready_r;
    assign bus.status_out = status_r;
    assign bus.fill       = fill_r;
endmodule

// File: doc/deserializer_fifo.md
Name: deserializer_fifo

Overview:
Parametrised serial-to-parallel converter. It accepts one bit per cycle, qualified by write_in, and assembles WORD_WIDTH-bit words. Completed words are buffered in a FIFO_DEPTH-entry output queue and presented through a data_ready/ack_in handshake. It supersedes the fixed 8-bit single-word deserializer in the 100 kHz serial datapath, adding configurable width, bit order and output buffering.

Parameters:
WORD_WIDTH, 8, bits per assembled word (>= 2)
FIFO_DEPTH, 4, number of completed words held (>= 1)
MSB_FIRST, 1, 1: first received bit lands in data_out[WORD_WIDTH-1]; 0: first bit lands in data_out[0]

Ports:
clock  input  1  system clock (100 kHz target); all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  1  serial data bit
write_in  input  1  data_in is valid this cycle
ack_in  input  1  consumer has taken data_out; pops the queue head
data_out  output  WORD_WIDTH  oldest completed word (queue head)
data_ready  output  1  data_out holds a valid word
status_out  output  1  busy: 1 = bits are not accepted
fill  output  $clog2(FIFO_DEPTH+1)  number of words currently queued

Behaviour:
- Reset (asynchronous, active-high), effective immediately and held while reset is high:
  - bit counter = 0, shift register = 0, queue emptied;
  - data_out = 0, data_ready = 0, status_out = 0, fill = 0.
- Reset asserted mid-word or mid-queue discards all partial and queued data. No word is emitted.
- Accept condition: write_in=1 and status_out=0 at a rising edge. data_in is then shifted in and the bit counter increments.
- write_in=1 while status_out=1: the bit is dropped. Counter and shift register are unchanged.
- Word completion: the edge that accepts the WORD_WIDTH-th bit pushes the assembled word into the queue tail and clears the bit counter.
  - Latency: data_ready and data_out reflect the word in the cycle immediately after that edge.
- Bit order:
  - MSB_FIRST=1: left shift; the first bit ends in the MSB.
  - MSB_FIRST=0: right shift; the first bit ends in the LSB.
- Handshake:
  - data_ready = (fill != 0).
  - data_out = queue head, held stable until it is popped.
  - data_out = 0 when the queue is empty.
- Pop: ack_in=1 and data_ready=1 at an edge removes the head. The next word (or 0) appears the following cycle.
- ack_in while data_ready=0 is ignored.
- ack_in held high pops one word per cycle.
- status_out = (fill == FIFO_DEPTH). It is derived from registered state only, with no combinational path from ack_in.
- Simultaneous push and pop (fill not full): head popped, new word appended, fill unchanged.
  - Wrap-around of the queue pointers is seamless.
- Queue full plus ack_in in the same cycle: a bit offered that cycle is dropped, because status_out was 1. status_out falls the next cycle.
- A partial word in the shift register is retained indefinitely. It is never timed out or flushed.
- Full/empty guards: never push when full, never pop when empty; fill never exceeds FIFO_DEPTH or underflows.

Test Plan:
1. Defaults (WORD_WIDTH=8, MSB_FIRST=1): send bits 1,0,1,1,0,0,1,0 on consecutive cycles with write_in=1 -> one cycle after the 8th edge: data_ready=1, data_out=0xB2, fill=1. Values hold stable for 10 idle cycles with no ack.
2. MSB_FIRST=0, same bit sequence -> data_out=0x4D. Then ack_in for one cycle -> next cycle data_ready=0, data_out=0x00, fill=0.
3. write_in gaps: send 0xA5 (MSB first) with write_in low on random cycles and data_in toggling during the gaps -> data_out=0xA5. Gap bits are not captured.
4. Fill queue without ack (FIFO_DEPTH=4): words 0x01,0x02,0x03,0x04 -> fill=4, status_out=1. Five more bits with write_in=1 are dropped. Ack four times -> 0x01..0x04 in order, status_out=0 after the first pop. The next complete word after that is correct.
5. Simultaneous push/pop: fill=2; the 8th bit of 0x5A is accepted on the same edge as ack_in -> fill stays 2, the head advances, and 0x5A is later read out last.
6. Reset mid-operation: assert reset asynchronously (between edges) after 5 bits of a word with 2 words queued -> outputs go to 0 immediately. After release, a fresh 8-bit word 0xFF is output correctly with no residue from the old partial word.
